// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Saturating cycle counter for the arbiter's BUSY watchdog; expired marks the
// last cycle a transaction may stay outstanding.
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and D accesses onto one memory port with a hung-access timeout.
// Define ARB_ROUND_ROBIN_EN to break IF/D ties by alternating instead of D priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                bus_err,
  output logic                owner
);

  state_t state, state_nxt;
  logic   pick_d;
  logic   err;
  logic   expired;
  logic   any_req;

  assign any_req = if_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= OWN_D;
    end else if (state == RESP) begin
      last_grant <= owner;
    end
  end
`endif

  always_comb begin
    pick_d = d_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (d_req && if_req) begin
      pick_d = (last_grant == OWN_IF);
    end
`endif
  end

  arb_timeout_ctr #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .en     (state == BUSY),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mem_ack wins over an expiry landing on the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (mem_ack || expired) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side fields are captured once at grant so they stay frozen in BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_IF;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= pick_d ? OWN_D : OWN_IF;
            mem_we    <= pick_d & d_we;
            mem_addr  <= pick_d ? d_addr : if_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
            mem_be    <= (pick_d && d_we) ? d_be : '1;
            err       <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (owner == OWN_D) d_rdata <= mem_rdata;
            else                if_rdata <= mem_rdata;
          end else if (expired) begin
            if (owner == OWN_D) d_rdata <= '0;
            else                if_rdata <= '0;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req = (state == BUSY);
  assign if_ack  = (state == RESP) && (owner == OWN_IF);
  assign d_ack   = (state == RESP) && (owner == OWN_D);
  assign bus_err = (state == RESP) && err;

endmodule
